// File: rtl/img_proc_pkg.sv
// Shared types and frame constants for the image-processing blocks.
package img_proc_pkg;

    localparam int COORD_W = 11;
    localparam int FRAME_W = 640;
    localparam int FRAME_H = 480;

    typedef enum logic [1:0] {
        ABSENT,
        ACQUIRE,
        TRACK,
        HOLD
    } tracker_state_t;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/coord_history.sv
// Per-axis ring of the last DEPTH accepted samples with a running sum;
// the average is the sum shifted down by log2(DEPTH).
module coord_history
    import img_proc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               push,
    input  logic               fill,
    input  logic               clear,
    input  logic [COORD_W-1:0] sample,
    output logic [COORD_W-1:0] avg
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = (AW > 0) ? AW : 1;
    localparam int SUM_W = COORD_W + AW;

    logic [COORD_W-1:0] ring [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [SUM_W-1:0]   sum;

    // wr_ptr always points at the oldest entry, which a push replaces
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            wr_ptr <= '0;
            sum    <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            wr_ptr <= '0;
            sum    <= '0;
        end else if (fill) begin
            for (int i = 0; i < DEPTH; i++) ring[i] <= sample;
            wr_ptr <= '0;
            sum    <= SUM_W'(sample) << AW;
        end else if (push) begin
            ring[wr_ptr] <= sample;
            sum          <= sum + SUM_W'(sample) - SUM_W'(ring[wr_ptr]);
            wr_ptr       <= wr_ptr + 1'b1;
        end
    end

    assign avg = COORD_W'(sum >> AW);

endmodule

// File: rtl/coord_tracker.sv
// Debounced target tracker: acquires after consecutive good frames, rejects
// outliers, averages position over DEPTH frames and offers it on a valid/ready port.
module coord_tracker
    import img_proc_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PRESENT_ON  = 3,
    parameter int PRESENT_OFF = 5,
    parameter int MAX_JUMP    = 128
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [COORD_W-1:0] iRow,
    input  logic [COORD_W-1:0] iCol,
    input  logic               iVALID_COORD,
    input  logic               iPresent,
    output logic [COORD_W-1:0] oRow,
    output logic [COORD_W-1:0] oCol,
    output logic               oVALID,
    input  logic               iREADY,
    output logic               oPresent,
    output logic               oDROP
);

    localparam int CNT_MAX = (PRESENT_ON > PRESENT_OFF) ? PRESENT_ON : PRESENT_OFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   ON_LIM  = CNT_W'(PRESENT_ON);
    localparam logic [CNT_W-1:0]   OFF_LIM = CNT_W'(PRESENT_OFF);
    localparam logic [COORD_W-1:0] JUMP    = COORD_W'(MAX_JUMP);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(FRAME_H - 1);
    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(FRAME_W - 1);

    tracker_state_t     state;
    logic [CNT_W-1:0]   acq_cnt, miss_cnt;
    logic [CNT_W-1:0]   acq_next, miss_next;
    logic [COORD_W-1:0] avg_row, avg_col;
    logic               frame_good, frame_hit, acquired, lost;
    logic               hist_push, hist_fill, hist_clear;
    logic               load_s1, load_s2;
    logic [COORD_W-1:0] res_row, res_col;

    // Frame classification and history control; the history updates on the
    // same edge as the state so the average is current one cycle later.
    always_comb begin
        frame_good = iVALID_COORD && iPresent && (iRow <= ROW_MAX) && (iCol <= COL_MAX);
        frame_hit  = frame_good && (abs_diff(iRow, avg_row) <= JUMP)
                                && (abs_diff(iCol, avg_col) <= JUMP);
        acq_next   = acq_cnt + 1'b1;
        miss_next  = miss_cnt + 1'b1;
        acquired   = frame_good && (acq_next >= ON_LIM);
        lost       = !frame_hit && (miss_next >= OFF_LIM);
        hist_push  = 1'b0;
        hist_fill  = 1'b0;
        hist_clear = 1'b0;
        if (iVALID_COORD) begin
            unique case (state)
                ABSENT, ACQUIRE: hist_fill = acquired;
                TRACK, HOLD: begin
                    hist_push  = frame_hit;
                    hist_clear = lost;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= ABSENT;
            acq_cnt  <= '0;
            miss_cnt <= '0;
            oPresent <= 1'b0;
            load_s1  <= 1'b0;
        end else begin
            load_s1 <= 1'b0;
            if (iVALID_COORD) begin
                unique case (state)
                    ABSENT, ACQUIRE: begin
                        if (acquired) begin
                            state    <= TRACK;
                            acq_cnt  <= '0;
                            miss_cnt <= '0;
                            oPresent <= 1'b1;
                            load_s1  <= 1'b1;
                        end else if (frame_good) begin
                            state   <= ACQUIRE;
                            acq_cnt <= acq_next;
                        end else begin
                            state   <= ABSENT;
                            acq_cnt <= '0;
                        end
                    end
                    TRACK, HOLD: begin
                        if (frame_hit) begin
                            state    <= TRACK;
                            miss_cnt <= '0;
                            load_s1  <= 1'b1;
                        end else if (lost) begin
                            state    <= ABSENT;
                            miss_cnt <= '0;
                            oPresent <= 1'b0;
                        end else begin
                            state    <= HOLD;
                            miss_cnt <= miss_next;
                            load_s1  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    coord_history #(.DEPTH(DEPTH)) u_row_hist (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .push   (hist_push),
        .fill   (hist_fill),
        .clear  (hist_clear),
        .sample (iRow),
        .avg    (avg_row)
    );

    coord_history #(.DEPTH(DEPTH)) u_col_hist (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .push   (hist_push),
        .fill   (hist_fill),
        .clear  (hist_clear),
        .sample (iCol),
        .avg    (avg_col)
    );

    // Snapshot the post-update average, then present it; a new load while the
    // consumer is stalled replaces the pending result and flags the loss.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            load_s2 <= 1'b0;
            res_row <= '0;
            res_col <= '0;
            oRow    <= '0;
            oCol    <= '0;
            oVALID  <= 1'b0;
            oDROP   <= 1'b0;
        end else begin
            load_s2 <= load_s1;
            if (load_s1) begin
                res_row <= avg_row;
                res_col <= avg_col;
            end
            oDROP <= 1'b0;
            if (load_s2) begin
                oRow   <= res_row;
                oCol   <= res_col;
                oVALID <= 1'b1;
                oDROP  <= oVALID && !iREADY;
            end else if (oVALID && iREADY) begin
                oVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_coord_tracker.sv
// Scoreboard bench for coord_tracker: a frame-level reference model queues
// expected results and a monitor checks every consumed output against them.
module tb_coord_tracker;

    localparam int DEPTH       = 4;
    localparam int PRESENT_ON  = 3;
    localparam int PRESENT_OFF = 5;
    localparam int MAX_JUMP    = 128;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b0;
    logic [10:0] iRow = '0;
    logic [10:0] iCol = '0;
    logic        iVALID_COORD = 1'b0;
    logic        iPresent = 1'b0;
    logic        iREADY = 1'b1;
    logic [10:0] oRow, oCol;
    logic        oVALID, oPresent, oDROP;

    coord_tracker #(
        .DEPTH(DEPTH), .PRESENT_ON(PRESENT_ON),
        .PRESENT_OFF(PRESENT_OFF), .MAX_JUMP(MAX_JUMP)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iRow(iRow), .iCol(iCol),
        .iVALID_COORD(iVALID_COORD), .iPresent(iPresent),
        .oRow(oRow), .oCol(oCol), .oVALID(oVALID), .iREADY(iREADY),
        .oPresent(oPresent), .oDROP(oDROP)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int row;
        int col;
        bit present;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   assertions = 0;
    int   failures   = 0;
    int   cyc        = 0;
    bit   mon_en     = 1'b0;
    int   drop_seen  = 0;

    // Reference model: streak of good frames, run of misses, last DEPTH samples
    bit m_tracking;
    int m_streak;
    int m_misses;
    int m_hrow[$];
    int m_hcol[$];
    int last_row, last_col;
    bit last_emit;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_tracking = 1'b0;
        m_streak   = 0;
        m_misses   = 0;
        m_hrow.delete();
        m_hcol.delete();
    endtask

    function automatic int avgRow();
        int s = 0;
        foreach (m_hrow[i]) s += m_hrow[i];
        return s / DEPTH;
    endfunction

    function automatic int avgCol();
        int s = 0;
        foreach (m_hcol[i]) s += m_hcol[i];
        return s / DEPTH;
    endfunction

    task automatic modelFrame(input int row, input int col, input bit present,
                              output bit emit, output int er, output int ec);
        bit good;
        int ar, ac, dr, dc;
        good = present && (row <= 479) && (col <= 639);
        emit = 1'b0;
        er   = 0;
        ec   = 0;
        if (!m_tracking) begin
            if (good) begin
                m_streak++;
                if (m_streak == PRESENT_ON) begin
                    m_tracking = 1'b1;
                    m_misses   = 0;
                    m_hrow.delete();
                    m_hcol.delete();
                    for (int i = 0; i < DEPTH; i++) begin
                        m_hrow.push_back(row);
                        m_hcol.push_back(col);
                    end
                    emit = 1'b1;
                    er   = row;
                    ec   = col;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            ar = avgRow();
            ac = avgCol();
            dr = (row > ar) ? row - ar : ar - row;
            dc = (col > ac) ? col - ac : ac - col;
            if (good && dr <= MAX_JUMP && dc <= MAX_JUMP) begin
                void'(m_hrow.pop_front());
                void'(m_hcol.pop_front());
                m_hrow.push_back(row);
                m_hcol.push_back(col);
                m_misses = 0;
                emit = 1'b1;
                er   = avgRow();
                ec   = avgCol();
            end else begin
                m_misses++;
                if (m_misses == PRESENT_OFF) begin
                    modelReset();
                end else begin
                    emit = 1'b1;
                    er   = ar;
                    ec   = ac;
                end
            end
        end
    endtask

    // One frame pulse, then gap-1 idle cycles with junk on the data inputs
    task automatic applyStimulus(input int row, input int col, input bit present,
                                 input int gap);
        bit emit;
        int er, ec;
        exp_t e;
        @(negedge iCLK);
        iRow         = 11'(row);
        iCol         = 11'(col);
        iPresent     = present;
        iVALID_COORD = 1'b1;
        modelFrame(row, col, present, emit, er, ec);
        last_emit = emit;
        last_row  = er;
        last_col  = ec;
        if (emit && mon_en) begin
            e.row     = er;
            e.col     = ec;
            e.present = m_tracking;
            e.cyc     = cyc + 3;
            sb_q.push_back(e);
        end
        @(negedge iCLK);
        iVALID_COORD = 1'b0;
        iRow         = 11'($urandom_range(0, 2047));
        iCol         = 11'($urandom_range(0, 2047));
        iPresent     = 1'($urandom_range(0, 1));
        repeat (gap - 1) @(negedge iCLK);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge iCLK);
            n++;
        end
        checkOutput({name, "_pending"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    // Monitor: every accepted result must match the oldest queued expectation
    always @(negedge iCLK) begin
        if (mon_en && iRST) begin
            checkOutput("no_drop", oDROP, 0);
            if (oVALID && iREADY) begin
                exp_t e;
                assertions++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_result: got row %0d col %0d, expected no result",
                             oRow, oCol);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("result_row", oRow, e.row);
                    checkOutput("result_col", oCol, e.col);
                    checkOutput("result_present", oPresent, e.present);
                    checkOutput("result_latency", cyc, e.cyc);
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (iRST && oDROP) drop_seen++;
    end

    task automatic handshakeTest();
        int ra, ca, rb, cb, rc, cc;
        mon_en    = 1'b0;
        iREADY    = 1'b0;
        drop_seen = 0;
        applyStimulus(102, 201, 1, 4);
        ra = last_row;
        ca = last_col;
        #1;
        checkOutput("hs_first_valid", oVALID, 1);
        checkOutput("hs_first_row", oRow, ra);
        checkOutput("hs_first_col", oCol, ca);
        repeat (3) @(negedge iCLK);
        #1;
        checkOutput("hs_stall_row", oRow, ra);
        applyStimulus(110, 205, 1, 4);
        rb = last_row;
        cb = last_col;
        #1;
        checkOutput("hs_drop_count", drop_seen, 1);
        checkOutput("hs_second_row", oRow, rb);
        checkOutput("hs_second_col", oCol, cb);
        checkOutput("hs_second_valid", oVALID, 1);
        applyStimulus(114, 209, 1, 2);
        rc = last_row;
        cc = last_col;
        iREADY = 1'b1;
        @(negedge iCLK);
        #1;
        checkOutput("hs_coincident_valid", oVALID, 1);
        checkOutput("hs_coincident_row", oRow, rc);
        checkOutput("hs_coincident_col", oCol, cc);
        checkOutput("hs_coincident_drop", oDROP, 0);
        repeat (2) @(negedge iCLK);
        #1;
        checkOutput("hs_cleared", oVALID, 0);
        checkOutput("hs_drop_total", drop_seen, 1);
        mon_en = 1'b1;
    endtask

    task automatic resetTest();
        int n = 0;
        mon_en = 1'b0;
        iREADY = 1'b0;
        applyStimulus(116, 210, 1, 1);
        while (!oVALID && n < 10) begin
            @(negedge iCLK);
            n++;
        end
        checkOutput("rst_pre_valid", oVALID, 1);
        #2;
        iRST = 1'b0;
        #1;
        checkOutput("rst_async_valid", oVALID, 0);
        checkOutput("rst_async_row", oRow, 0);
        checkOutput("rst_async_col", oCol, 0);
        checkOutput("rst_async_present", oPresent, 0);
        checkOutput("rst_async_drop", oDROP, 0);
        modelReset();
        sb_q.delete();
        @(negedge iCLK);
        iRST   = 1'b1;
        iREADY = 1'b1;
        @(negedge iCLK);
        mon_en = 1'b1;
    endtask

    initial begin
        int base_r, base_c;
        modelReset();
        repeat (3) @(negedge iCLK);
        checkOutput("reset_valid", oVALID, 0);
        checkOutput("reset_row", oRow, 0);
        checkOutput("reset_col", oCol, 0);
        checkOutput("reset_present", oPresent, 0);
        checkOutput("reset_drop", oDROP, 0);
        iRST = 1'b1;
        @(negedge iCLK);
        mon_en = 1'b1;

        $display("[TB] acquire / outlier / average / loss");
        applyStimulus(100, 200, 1, 5);
        applyStimulus(100, 200, 1, 5);
        checkOutput("acq_present_low", oPresent, 0);
        applyStimulus(100, 200, 1, 5);
        checkOutput("acq_present_high", oPresent, 1);
        applyStimulus(400, 200, 1, 5);
        checkOutput("outlier_present", oPresent, 1);
        applyStimulus(104, 200, 1, 5);
        applyStimulus(108, 200, 1, 5);
        applyStimulus(112, 200, 1, 5);
        checkOutput("avg_model_row", last_row, 106);
        repeat (PRESENT_OFF) applyStimulus(0, 0, 0, 5);
        checkOutput("lost_present", oPresent, 0);
        drain("track");

        $display("[TB] range check");
        applyStimulus(100, 200, 1, 5);
        applyStimulus(100, 700, 1, 5);
        applyStimulus(100, 200, 1, 5);
        applyStimulus(100, 200, 1, 5);
        checkOutput("range_present", oPresent, 0);
        applyStimulus(100, 200, 1, 5);
        checkOutput("range_reacquired", oPresent, 1);
        drain("range");

        $display("[TB] handshake and async reset");
        handshakeTest();
        resetTest();

        $display("[TB] random frames");
        base_r = 240;
        base_c = 320;
        for (int k = 0; k < 150; k++) begin
            int sel, r, c;
            bit p;
            base_r += int'($urandom_range(0, 20)) - 10;
            base_c += int'($urandom_range(0, 20)) - 10;
            if (base_r < 150) base_r = 150;
            if (base_r > 330) base_r = 330;
            if (base_c < 150) base_c = 150;
            if (base_c > 490) base_c = 490;
            r   = base_r + int'($urandom_range(0, 16)) - 8;
            c   = base_c + int'($urandom_range(0, 16)) - 8;
            p   = 1'b1;
            sel = int'($urandom_range(0, 99));
            if (sel < 10) p = 1'b0;
            else if (sel < 15) c = 640 + int'($urandom_range(0, 60));
            else if (sel < 20) r = 480 + int'($urandom_range(0, 60));
            else if (sel < 28) r = (base_r + 300) % 480;
            applyStimulus(r, c, p, int'($urandom_range(4, 7)));
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/coord_tracker.md
COORD_TRACKER -- requirements
Module: coord_tracker

Interface
REQ-001 The module SHALL have a single clock, iCLK, and an asynchronous, active-low reset, iRST.
REQ-002 Parameters SHALL be: DEPTH (default 4; averaging window in frames, power of 2); PRESENT_ON (default 3; consecutive good frames needed to acquire); PRESENT_OFF (default 5; consecutive misses that end tracking); MAX_JUMP (default 128; outlier threshold in pixels).
REQ-003 Ports SHALL be, in this order:
- iCLK  in  1  clock.
- iRST  in  1  async active-low reset.
- iRow  in  11  per-frame centroid row.
- iCol  in  11  per-frame centroid column.
- iVALID_COORD  in  1  one-cycle pulse at frame start; iRow, iCol and iPresent are valid with it.
- iPresent  in  1  target detected in the frame.
- oRow  out  11  filtered row.
- oCol  out  11  filtered column.
- oVALID  out  1  output handshake valid.
- iREADY  in  1  consumer ready.
- oPresent  out  1  debounced presence (high in TRACK/HOLD).
- oDROP  out  1  one-cycle pulse: an unconsumed result was overwritten.

Function
REQ-004 A frame SHALL be "good" when iVALID_COORD=1, iPresent=1, iRow<=479 and iCol<=639; any other sampled frame SHALL be a "miss".
REQ-005 In TRACK/HOLD, a good frame SHALL be an outlier (treated as a miss) when |iRow-avgRow|>MAX_JUMP or |iCol-avgCol|>MAX_JUMP.
REQ-006 FSM states SHALL be ABSENT, ACQUIRE, TRACK and HOLD, and SHALL change only on cycles where iVALID_COORD=1.
REQ-007 ABSENT SHALL go to ACQUIRE on a good frame (acq_cnt=1) and stay on a miss.
REQ-008 In ACQUIRE, a good frame SHALL increment acq_cnt; on reaching PRESENT_ON the FSM SHALL go to TRACK and fill all DEPTH history entries with that sample. A miss SHALL return to ABSENT with acq_cnt=0.
REQ-009 In TRACK, a non-outlier good frame SHALL push the sample and stay in TRACK; a miss SHALL go to HOLD with miss_cnt=1 and no push.
REQ-010 In HOLD, a non-outlier good frame SHALL push the sample, clear miss_cnt and go to TRACK; a miss SHALL increment miss_cnt, and reaching PRESENT_OFF SHALL go to ABSENT and clear the history and sums.
REQ-011 History SHALL be a DEPTH-entry ring per axis with a running sum of width 11+log2(DEPTH): sum <= sum + new - oldest. The average SHALL be sum >> log2(DEPTH), truncating.
REQ-012 Each iVALID_COORD that leaves the FSM in TRACK or HOLD SHALL load a result: the post-update average, or the held average in HOLD.
REQ-013 Latency: the result SHALL appear on oRow/oCol with oVALID=1 after the second rising edge following the edge that samples iVALID_COORD.
REQ-014 oVALID SHALL stay high with stable data until oVALID&iREADY, and SHALL then clear on the next edge.
REQ-015 A load while oVALID=1 and iREADY=0 SHALL overwrite the data, keep oVALID=1 and pulse oDROP for one cycle.
REQ-016 A load coincident with oVALID&iREADY SHALL load the new data, keep oVALID=1 and not pulse oDROP.
REQ-017 No result SHALL be loaded in ABSENT or ACQUIRE; a pending result SHALL remain until consumed.

Reset
REQ-018 While iRST=0, the block SHALL force: state=ABSENT, counters=0, history=0, sums=0, oRow=0, oCol=0, oVALID=0, oPresent=0, oDROP=0.
REQ-019 Reset mid-operation SHALL discard any pending result immediately, with no oDROP pulse.

Structure
REQ-020 Package img_proc_pkg SHALL hold the tracker_state_t enum and the constants FRAME_W=640, FRAME_H=480 and COORD_W=11.
REQ-021 Sub-module coord_history (ring buffer plus running sum plus average) SHALL be instantiated once per axis; the FSM, outlier check and output register SHALL reside in coord_tracker.

Verification
REQ-022 Acquire: three good frames at (100,200) -> no oVALID after frames 1-2; after frame 3, oVALID with (100,200) and oPresent=1.
REQ-023 Average: TRACK at (100,200), then frames (104,200),(108,200),(112,200) -> outputs rows 101,103,106 (truncating).
REQ-024 Outlier/HOLD: in TRACK at (100,200), frame (400,200) -> output (100,200) and oPresent=1; five consecutive misses -> oPresent=0 and no further oVALID.
REQ-025 Handshake: iREADY held 0 across two results -> one oDROP pulse and the second data retained; iREADY=1 coincident with a load -> no oDROP.
REQ-026 Range/reset: iCol=700 with iPresent=1 in ACQUIRE -> returns to ABSENT; iRST pulsed low while oVALID=1 -> all outputs 0 asynchronously.
